// File: rtl/mdu_pkg.sv
// mdu_pkg: shared definitions for the multiply/divide unit and the ID-stage
// hazard decoder.
//   - MDU_OP_*        : 4-bit operation codes carried on the op input
//   - mdu_state_e     : FSM state encoding (MDU_IDLE, MDU_BUSY)
//   - MDU_*_CYCLES_DEF: default busy latencies
// Optional feature macro: MDU_MADD_EN. When it is defined, op codes 7-10
// (MADD/MADDU/MSUB/MSUBU) are live. When it is not defined, they decode as NOP.
package mdu_pkg;

  localparam logic [3:0] MDU_OP_NOP   = 4'd0;
  localparam logic [3:0] MDU_OP_MULT  = 4'd1;
  localparam logic [3:0] MDU_OP_MULTU = 4'd2;
  localparam logic [3:0] MDU_OP_DIV   = 4'd3;
  localparam logic [3:0] MDU_OP_DIVU  = 4'd4;
  localparam logic [3:0] MDU_OP_MTHI  = 4'd5;
  localparam logic [3:0] MDU_OP_MTLO  = 4'd6;
  localparam logic [3:0] MDU_OP_MADD  = 4'd7;
  localparam logic [3:0] MDU_OP_MADDU = 4'd8;
  localparam logic [3:0] MDU_OP_MSUB  = 4'd9;
  localparam logic [3:0] MDU_OP_MSUBU = 4'd10;

  typedef enum logic {
    MDU_IDLE = 1'b0,
    MDU_BUSY = 1'b1
  } mdu_state_e;

  localparam int unsigned MDU_MULT_CYCLES_DEF = 5;
  localparam int unsigned MDU_DIV_CYCLES_DEF  = 10;

endpackage

// File: rtl/mdu_arith.sv
// mdu_arith: purely combinational arithmetic for the multiply/divide unit.
// Ports:
//   op          in  4   operation code (MDU_OP_*)
//   rs, rt      in  32  operands A and B
//   hi, lo      in  32  current HI/LO (accumulate base; pass-through value)
//   result      out 64  {HI,LO} value the operation produces
//   div_by_zero out 1   DIV/DIVU with rt == 0
// Optional feature macro: MDU_MADD_EN enables the accumulate adder for
// MADD/MADDU/MSUB/MSUBU.
module mdu_arith
  import mdu_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [31:0] rs,
  input  logic [31:0] rt,
  input  logic [31:0] hi,
  input  logic [31:0] lo,
  output logic [63:0] result,
  output logic        div_by_zero
);

  logic [63:0] prod_s;
  logic [63:0] prod_u;
  logic        div_signed;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [31:0] b_safe;
  logic [31:0] q_mag;
  logic [31:0] r_mag;
  logic [31:0] quot;
  logic [31:0] rem;

  // The low 64 bits of a product of sign-extended operands give the signed product.
  assign prod_s = {{32{rs[31]}}, rs} * {{32{rt[31]}}, rt};
  assign prod_u = {32'd0, rs} * {32'd0, rt};

  // The signed divide runs on magnitudes and then fixes up the signs.
  // 0x80000000 / -1 works out to LO=0x80000000 and HI=0 without a special case.
  assign div_signed = (op == MDU_OP_DIV);
  assign a_mag      = (div_signed && rs[31]) ? (~rs + 32'd1) : rs;
  assign b_mag      = (div_signed && rt[31]) ? (~rt + 32'd1) : rt;
  assign b_safe     = (b_mag == 32'd0) ? 32'd1 : b_mag;
  assign q_mag      = a_mag / b_safe;
  assign r_mag      = a_mag % b_safe;
  assign quot       = (div_signed && (rs[31] ^ rt[31])) ? (~q_mag + 32'd1) : q_mag;
  assign rem        = (div_signed && rs[31]) ? (~r_mag + 32'd1) : r_mag;

  assign div_by_zero = (rt == 32'd0) && ((op == MDU_OP_DIV) || (op == MDU_OP_DIVU));

  always_comb begin
    result = {hi, lo};
    case (op)
      MDU_OP_MULT:  result = prod_s;
      MDU_OP_MULTU: result = prod_u;
      MDU_OP_DIV,
      MDU_OP_DIVU:  if (!div_by_zero) result = {rem, quot};
`ifdef MDU_MADD_EN
      MDU_OP_MADD:  result = {hi, lo} + prod_s;
      MDU_OP_MADDU: result = {hi, lo} + prod_u;
      MDU_OP_MSUB:  result = {hi, lo} - prod_s;
      MDU_OP_MSUBU: result = {hi, lo} - prod_u;
`endif
      default:      result = {hi, lo};
    endcase
  end

endmodule

// File: rtl/multiply_divide_unit.sv
// multiply_divide_unit: iterative-latency multiply/divide unit with
// architectural HI/LO registers.
// Parameters: MULT_CYCLES (1..15) and DIV_CYCLES (1..15) set the busy latency.
// Ports:
//   clk    in  1   rising-edge clock
//   reset  in  1   asynchronous active-low reset
//   start  in  1   qualifies op this cycle
//   op     in  4   operation code (MDU_OP_*)
//   rs, rt in  32  operands
//   busy   out 1   an operation is in flight (registered)
//   hi, lo out 32  HI/LO registers
// Optional feature macro: MDU_MADD_EN decodes MADD/MADDU/MSUB/MSUBU.
//
// state    | meaning
// MDU_IDLE | accepting ops; MTHI/MTLO write directly
// MDU_BUSY | counting cnt down; the latched result is written when cnt == 0
module multiply_divide_unit
  import mdu_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = MDU_MULT_CYCLES_DEF,
  parameter int unsigned DIV_CYCLES  = MDU_DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  op,
  input  logic [31:0] rs,
  input  logic [31:0] rt,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [3:0] MULT_LOAD = 4'(MULT_CYCLES - 1);
  localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYCLES - 1);

  mdu_state_e  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [63:0] result_q, result_d;
  logic        skip_wr_q, skip_wr_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;

  logic [63:0] arith_result;
  logic        arith_div0;

  mdu_arith u_arith (
    .op          (op),
    .rs          (rs),
    .rt          (rt),
    .hi          (hi_q),
    .lo          (lo_q),
    .result      (arith_result),
    .div_by_zero (arith_div0)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= MDU_IDLE;
      cnt_q     <= 4'd0;
      result_q  <= 64'd0;
      skip_wr_q <= 1'b0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      result_q  <= result_d;
      skip_wr_q <= skip_wr_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    result_d  = result_q;
    skip_wr_d = skip_wr_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    case (state_q)
      MDU_IDLE: begin
        if (start) begin
          case (op)
            MDU_OP_MULT, MDU_OP_MULTU
`ifdef MDU_MADD_EN
            , MDU_OP_MADD, MDU_OP_MADDU, MDU_OP_MSUB, MDU_OP_MSUBU
`endif
            : begin
              result_d  = arith_result;
              skip_wr_d = 1'b0;
              cnt_d     = MULT_LOAD;
              state_d   = MDU_BUSY;
            end
            MDU_OP_DIV, MDU_OP_DIVU: begin
              // A divide by zero still takes the full latency but leaves HI/LO alone.
              result_d  = arith_result;
              skip_wr_d = arith_div0;
              cnt_d     = DIV_LOAD;
              state_d   = MDU_BUSY;
            end
            MDU_OP_MTHI: hi_d = rs;
            MDU_OP_MTLO: lo_d = rs;
            default: ;
          endcase
        end
      end
      MDU_BUSY: begin
        // Any start while busy is ignored.
        if (cnt_q == 4'd0) begin
          if (!skip_wr_q) begin
            hi_d = result_q[63:32];
            lo_d = result_q[31:0];
          end
          state_d = MDU_IDLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = MDU_IDLE;
    endcase
  end

  assign busy = (state_q == MDU_BUSY);
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: doc/multiply_divide_unit.md
# multiply_divide_unit

Iterative-latency multiply/divide unit with architectural HI/LO registers. Sits in the EX stage beside the ALU. It accepts mult/div/mthi/mtlo operations from the ID/EX pipeline register and exposes `busy` to the hazard logic in ID, which stalls any HI/LO-touching instruction while an operation is in flight. HI/LO are read combinationally by EX for mfhi/mflo.

## Interface
- `MULT_CYCLES`, default 5: busy cycles for mult/multu (and madd family); range 1..15.
- `DIV_CYCLES`, default 10: busy cycles for div/divu; range 1..15.

- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-low reset; single clock domain.
- `start`  in  1  qualifies `op` for this cycle; stalls and bubbles arrive with `start`=0.
- `op`  in  4  operation code; encodings in `mdu_pkg`.
- `rs`  in  32  operand A, already forwarded.
- `rt`  in  32  operand B, already forwarded.
- `busy`  out  1  an operation is in flight.
- `hi`  out  32  HI register.
- `lo`  out  32  LO register.

## Operation
- Op encodings:
  - 0 NOP
  - 1 MULT
  - 2 MULTU
  - 3 DIV
  - 4 DIVU
  - 5 MTHI
  - 6 MTLO
  - 7 MADD, 8 MADDU, 9 MSUB, 10 MSUBU (macro only)
  - all others are NOP.
- FSM states: IDLE, BUSY. Holds a 4-bit down-counter `cnt`, latched op, and latched 64-bit result.
- IDLE, `start`=1, op ∈ {MULT..DIVU, MADD..MSUBU}:
  - compute the result from `rs`/`rt` (and current HI/LO for the madd family) and latch it;
  - load `cnt` = N−1, where N = MULT_CYCLES or DIV_CYCLES;
  - go to BUSY.
- BUSY: `cnt` decrements each cycle. At `cnt`==0, write the latched result to HI/LO and return to IDLE.
- IDLE, `start`=1, MTHI/MTLO: write `rs` into `hi`/`lo` at the next edge. Stay IDLE; `busy` stays 0.
- BUSY, `start`=1, any op: ignored. Upstream guarantees this never happens; the bench asserts it.
- Arithmetic:
  - MULT: signed 32×32→64. MULTU: unsigned. Write {HI,LO} = product.
  - DIV: signed. LO = quotient, truncated toward zero. HI = remainder, with the sign of the dividend.
  - DIV overflow case 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
  - DIVU: unsigned.
  - Divide by zero: still busy for DIV_CYCLES; HI/LO left unchanged.
  - MADD/MSUB: {HI,LO} ± signed product, modulo 2^64. MADDU/MSUBU: unsigned product.

## Timing
- Reset values (asynchronous, immediate on `reset`=0): `busy`=0, `hi`=0, `lo`=0, state IDLE, `cnt`=0.
- Start accepted at edge E0:
  - `busy`=1 for exactly N cycles following E0;
  - new HI/LO are visible on the same cycle `busy` falls;
  - `busy` is registered, with no combinational path from `start`.
- MTHI/MTLO at E0: new value is visible after E0.
- Back-to-back: a `start` in the first cycle with `busy`=0 after completion is accepted normally.
- `hi`/`lo` are stable, with their old values, throughout BUSY. Reads during BUSY return pre-operation values; ID stalls prevent architecturally wrong reads.
- Reset asserted mid-operation: abort immediately. The pending result is discarded, outputs take reset values, and `busy` drops within the same cycle.

## Configuration
- `MDU_MADD_EN` defined: op codes 7–10 are decoded and accumulate into HI/LO with MULT_CYCLES latency.
- Not defined: op codes 7–10 are treated as NOP, and the accumulate adder is not synthesised.

## Structure
- `mdu_pkg` holds:
  - op-code localparams (`MDU_OP_*`);
  - state encoding (`MDU_IDLE`, `MDU_BUSY`);
  - the default latency constants.
- The ID-stage hazard decoder includes `mdu_pkg` so the op mapping is shared.
- One sub-module, `mdu_arith`: purely combinational; takes op, `rs`, `rt`, HI, LO and produces the 64-bit result and a div-by-zero flag. `multiply_divide_unit` keeps only the FSM, counter and registers.

## Test plan
- MULT rs=0xFFFFFFFD, rt=5 → `busy` high exactly 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFF1.
- DIVU 7/2 → `busy` 10 cycles; lo=3, hi=1. DIV 0xFFFFFFF9/2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIV 0x80000000/0xFFFFFFFF → lo=0x80000000, hi=0.
- HI=0x11, LO=0x22, then DIVU 5/0 → `busy` 10 cycles; hi=0x11, lo=0x22 unchanged.
- MTHI rs=0xDEADBEEF while idle → hi=0xDEADBEEF next cycle, `busy` stays 0. `start`=1 with MTLO during BUSY → lo unchanged.
- MULT 3×4 started, `reset` pulled low on busy cycle 2 → `busy`=0, hi=lo=0 immediately; no later write.
- `MDU_MADD_EN` defined, HI=0, LO=0xFFFFFFFF, MADDU 1×1 → hi=1, lo=0 after 5 cycles. Macro undefined, same stimulus → no busy, HI/LO unchanged.
